// File: rtl/lvt_mpram.sv
// Multi-ported RAM: NUM_WR x NUM_RD replicated single-write banks, with a Live Value Table
// that records which write port last wrote each address. A reset sweep zeroes all storage.
module lvt_mpram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_valid,
    output logic                           init_busy,
    output logic                           collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                          state, state_next;
    logic [ADDR_WIDTH-1:0]           cnt;
    logic                            sweep;
    logic                            accept;
    logic [NUM_WR-1:0]               wr_eff;
    logic                            coll_next;
    logic [NUM_RD*DATA_WIDTH-1:0]    rd_word;
    logic [NUM_WR*NUM_RD*DATA_WIDTH-1:0] bank_q;
    logic [LW-1:0]                   lvt [DEPTH];

    logic [ADDR_WIDTH-1:0] wa [NUM_WR];
    logic [DATA_WIDTH-1:0] wd [NUM_WR];
    logic [ADDR_WIDTH-1:0] ra [NUM_RD];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wport
        assign wa[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rport
        assign ra[r] = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign sweep     = (state == INIT);
    assign accept    = (state == RUN) && !rst;
    assign init_busy = (state == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // A write is dropped whenever a higher-index port targets the same address.
    always_comb begin
        wr_eff    = '0;
        coll_next = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_eff[w] = wr_en[w] && accept;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            for (int v = w + 1; v < NUM_WR; v++) begin
                if (accept && wr_en[w] && wr_en[v] && (wa[w] == wa[v])) begin
                    wr_eff[w] = 1'b0;
                    coll_next = 1'b1;
                end
            end
        end
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wbank
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rbank
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (sweep) begin
                    mem[cnt] <= '0;
                end else if (wr_eff[w]) begin
                    mem[wa[w]] <= wd[w];
                end
            end

            assign bank_q[(w*NUM_RD + r)*DATA_WIDTH +: DATA_WIDTH] = mem[ra[r]];
        end
    end

    always_ff @(posedge clk) begin
        if (sweep) begin
            lvt[cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_eff[w]) begin
                    lvt[wa[w]] <= LW'(w);
                end
            end
        end
    end

    // Winners are unique per address, so at most one bypass source can match a read.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_word[r*DATA_WIDTH +: DATA_WIDTH] =
                bank_q[(int'(lvt[ra[r]])*NUM_RD + r)*DATA_WIDTH +: DATA_WIDTH];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_eff[w] && (wa[w] == ra[r])) begin
                        rd_word[r*DATA_WIDTH +: DATA_WIDTH] = wd[w];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= '0;
            collision <= 1'b0;
        end else begin
            collision <= coll_next;
            for (int r = 0; r < NUM_RD; r++) begin
                rd_valid[r] <= accept && rd_en[r];
                if (accept && rd_en[r]) begin
                    rd_data[r*DATA_WIDTH +: DATA_WIDTH] <= rd_word[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule
